// File: rtl/ara_pkg.sv
// Shared vector-unit types used by the broadcast sequencer.
//   elen_t : one vector element as carried on the lane broadcast chain.
package ara_pkg;
  localparam int unsigned ELEN = 64;
  typedef logic [ELEN-1:0] elen_t;
endpackage

// File: rtl/matmul_pkg.sv
// Matmul-side constants and types for the broadcast chain sequencer.
//   LenWidth        : width of the job element-count field.
//   bc_seq_state_e  : sequencer FSM state.
package matmul_pkg;
  localparam int unsigned LenWidth = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bc_seq_state_e;
endpackage

// File: rtl/bc_strobe_pipe.sv
// Per-lane capture strobe delay line. One register per lane so that the
// strobe for lane i follows the element down the chain by i cycles.
//   clk_i, rst_ni : clock, async active-low reset
//   inject_i      : element injected at the head of the chain this cycle
//   strobe_o      : bit i = lane i captures chain data this cycle
module bc_strobe_pipe #(
  parameter int unsigned NrLanes = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inject_i,
  output logic [NrLanes-1:0] strobe_o
);

  logic [NrLanes-1:0] vld_pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_pipe_q <= '0;
    else         vld_pipe_q <= {vld_pipe_q[NrLanes-2:0], inject_i};
  end

  assign strobe_o = vld_pipe_q;

endmodule

// File: rtl/bc_chain_sequencer.sv
// Broadcast chain sequencer: accepts a job of cfg_len_i elements, pulls them
// from the operand requester and injects them into the lane broadcast chain,
// then waits for the last element to reach the final lane before done_o.
//   cfg_valid_i/cfg_ready_o/cfg_len_i   : job request handshake
//   data_valid_i/data_ready_o/data_i    : element stream in
//   stall_i                             : lanes pause new injections
//   bc_data_o                           : chain head data (held between elements)
//   bc_valid_o                          : per-lane capture strobes
//   busy_o, done_o                      : status / one-cycle completion pulse
module bc_chain_sequencer
  import ara_pkg::*;
  import matmul_pkg::*;
#(
  parameter int unsigned NrLanes  = 4,
  parameter int unsigned LenWidth = matmul_pkg::LenWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [LenWidth-1:0] cfg_len_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  elen_t               data_i,
  input  logic                stall_i,
  output elen_t               bc_data_o,
  output logic [NrLanes-1:0]  bc_valid_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned DrainW = $clog2(NrLanes);

  bc_seq_state_e       state_q;
  logic [LenWidth-1:0] rem_q;
  logic [DrainW-1:0]   drain_q;
  elen_t               bc_data_q;
  logic                done_q;
  logic                cfg_hs, data_hs;

  assign cfg_ready_o  = (state_q == IDLE);
  // Ready is combinational on stall_i so a stall can never race an accept.
  assign data_ready_o = (state_q == RUN) && !stall_i;
  assign cfg_hs       = cfg_valid_i && cfg_ready_o;
  assign data_hs      = data_valid_i && data_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      drain_q   <= '0;
      bc_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (data_hs) bc_data_q <= data_i;
      case (state_q)
        IDLE: begin
          if (cfg_hs) begin
            if (cfg_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              rem_q   <= cfg_len_i;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (data_hs) begin
            if (rem_q != '0) rem_q <= rem_q - LenWidth'(1);
            if (rem_q == LenWidth'(1)) begin
              state_q <= DRAIN;
              drain_q <= DrainW'(NrLanes - 1);
            end
          end
        end
        DRAIN: begin
          // Counter reaches 0 in the cycle the last lane strobes; done is
          // registered one cycle early so it lines up with that strobe.
          if (drain_q == DrainW'(1)) done_q <= 1'b1;
          if (drain_q == '0) state_q <= IDLE;
          else               drain_q <= drain_q - DrainW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bc_strobe_pipe #(
    .NrLanes (NrLanes)
  ) i_strobe_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inject_i (data_hs),
    .strobe_o (bc_valid_o)
  );

  assign bc_data_o = bc_data_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

endmodule

// File: tb/tb_bc_chain_sequencer.sv
module tb_bc_chain_sequencer;
  import ara_pkg::*;

  localparam int NL = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          cfg_valid_i, cfg_ready_o;
  logic [LW-1:0] cfg_len_i;
  logic          data_valid_i, data_ready_o;
  elen_t         data_i;
  logic          stall_i;
  elen_t         bc_data_o;
  logic [NL-1:0] bc_valid_o;
  logic          busy_o, done_o;

  bc_chain_sequencer #(.NrLanes(NL), .LenWidth(LW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_len_i    (cfg_len_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .stall_i      (stall_i),
    .bc_data_o    (bc_data_o),
    .bc_valid_o   (bc_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected lane capture events and done pulses, keyed by cycle.
  typedef struct { int cyc; elen_t data; } ev_t;
  ev_t lane_q[NL][$];
  int  done_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: samples registered outputs at the falling edge and pops the
  // scoreboard whenever an event is due.
  initial begin
    elen_t exp_head;
    bit    e;
    exp_head = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) exp_head = '0;
      for (int i = 0; i < NL; i++) begin
        e = (lane_q[i].size() > 0) && (lane_q[i][0].cyc == cyc);
        chk($sformatf("bc_valid[%0d]", i), 64'(bc_valid_o[i]), 64'(e));
        if (e) begin
          if (i == 0) exp_head = lane_q[0][0].data;
          void'(lane_q[i].pop_front());
        end
      end
      chk("bc_data", bc_data_o, exp_head);
      e = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", 64'(done_o), 64'(e));
      if (e) void'(done_q.pop_front());
    end
  end

  // Stimulus + reference model. The model tracks a job only as "elements
  // still owed" and "cycle at which the last lane sees the last element".
  initial begin
    int    c, running, rem, busy_end, zero_done, gap, len, rst_state;
    bit    idle, cv, dv, st;
    elen_t d;
    running = 0; rem = 0; busy_end = -1; zero_done = -1; gap = 0; rst_state = 0;
    rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_len_i = '0;
    data_valid_i = 1'b0; data_i = '0; stall_i = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_valid", 64'(bc_valid_o), 64'(0));
    chk("rst_data", bc_data_o, 64'(0));
    chk("rst_cfg_ready", 64'(cfg_ready_o), 64'(1));
    #1 rst_ni = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #2;
      c = cyc;
      if (rst_state == 1) begin
        rst_ni = 1'b1;
        rst_state = 2;
      end
      idle = (running == 0) && (c > busy_end);

      // Abort one job in the middle of its drain.
      if (rst_state == 0 && k > 1500 && running == 0 && c == busy_end - 1) begin
        cfg_valid_i = 1'b0; data_valid_i = 1'b0; stall_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_done", 64'(done_o), 64'(0));
        chk("abort_valid", 64'(bc_valid_o), 64'(0));
        chk("abort_data", bc_data_o, 64'(0));
        for (int i = 0; i < NL; i++) lane_q[i].delete();
        done_q.delete();
        running = 0; busy_end = -1; rst_state = 1;
        continue;
      end

      if (idle) begin
        cv = (k < 2900) && (c > zero_done) && ($urandom_range(0, 2) == 0);
        len = $urandom_range(0, 9);
        if (len > 6) len = (len == 9) ? 12 : len - 6;
        cfg_len_i = LW'(len);
      end else begin
        cv = ($urandom_range(0, 7) == 0);       // must be ignored while busy
        cfg_len_i = LW'($urandom);
        len = 0;
      end
      if (gap == 0 && $urandom_range(0, 40) == 0) gap = 5;
      if (gap > 0) begin
        dv = 1'b0; gap--;
      end else begin
        dv = ($urandom_range(0, 9) < 7);
      end
      st = ($urandom_range(0, 3) == 0);
      d  = {$urandom, $urandom};
      cfg_valid_i = cv; data_valid_i = dv; stall_i = st; data_i = d;
      #1;
      chk("cfg_ready", 64'(cfg_ready_o), 64'(idle));
      chk("data_ready", 64'(data_ready_o), 64'((running != 0) && !st));
      chk("busy", 64'(busy_o), 64'((running != 0) || (c <= busy_end)));

      if (idle && cv) begin
        if (len == 0) begin
          done_q.push_back(c + 1);
          zero_done = c + 1;
        end else begin
          running = 1; rem = len;
        end
      end else if (running != 0 && dv && !st) begin
        for (int i = 0; i < NL; i++) lane_q[i].push_back('{c + 1 + i, d});
        rem--;
        if (rem == 0) begin
          running = 0;
          busy_end = c + NL;
          done_q.push_back(c + NL);
        end
      end
    end

    @(negedge clk); #2;
    cfg_valid_i = 1'b0; data_valid_i = 1'b0; stall_i = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("job_left_running", 64'(running), 64'(0));
    chk("done_pending", 64'(done_q.size()), 64'(0));
    for (int i = 0; i < NL; i++)
      chk($sformatf("lane%0d_pending", i), 64'(lane_q[i].size()), 64'(0));
    chk("reset_exercised", 64'(rst_state), 64'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bc_chain_sequencer.md
BC_CHAIN_SEQUENCER -- requirements
Module: bc_chain_sequencer

Interface
REQ-001 SHALL have parameter NrLanes, default 4, number of lanes in the broadcast register chain (>=2).
REQ-002 SHALL have parameter LenWidth, default 16, width of the element-count field.
REQ-003 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_valid_i  input  1  broadcast job request.
REQ-006 SHALL have port cfg_ready_o  output  1  job accepted when cfg_valid_i && cfg_ready_o.
REQ-007 SHALL have port cfg_len_i  input  LenWidth  number of elements in the job.
REQ-008 SHALL have port data_valid_i  input  1  element available from operand requester.
REQ-009 SHALL have port data_ready_o  output  1  element consumed when data_valid_i && data_ready_o.
REQ-010 SHALL have port data_i  input  elen_t  element to broadcast.
REQ-011 SHALL have port stall_i  input  1  lanes request an injection pause.
REQ-012 SHALL have port bc_data_o  output  elen_t  head of chain, drives lane 0 chain input.
REQ-013 SHALL have port bc_valid_o  output  NrLanes  per-lane capture strobe, bit i for lane i.
REQ-014 SHALL have port busy_o  output  1  high when not in IDLE.
REQ-015 SHALL have port done_o  output  1  single-cycle job-complete pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN; cfg_ready_o = (state==IDLE).
REQ-017 IDLE: on cfg handshake with cfg_len_i>0 -> RUN, load remaining count = cfg_len_i; with cfg_len_i==0 -> stay IDLE, done_o high next cycle, no strobes.
REQ-018 RUN: data_ready_o = !stall_i; each data handshake decrements the count; the handshake consuming the last element -> DRAIN.
REQ-019 data_ready_o SHALL be 0 in IDLE and DRAIN.
REQ-020 Element accepted at cycle t SHALL appear on bc_data_o and bc_valid_o[0] at t+1 (registered).
REQ-021 bc_valid_o[i] SHALL equal bc_valid_o[i-1] delayed one cycle, matching one chain register per lane; lane i captures chain data at t+1+i.
REQ-022 bc_data_o SHALL hold its value on cycles without a handshake; only bc_valid_o[0] goes low (bubble).
REQ-023 stall_i SHALL only gate new injections; in-flight strobes always propagate unchanged.
REQ-024 DRAIN: down-counter of NrLanes-1 cycles, unaffected by stall_i; on expiry -> IDLE.
REQ-025 done_o SHALL be high exactly in the cycle bc_valid_o[NrLanes-1] is high for the final element (same cycle as DRAIN->IDLE decision), for non-zero jobs.
REQ-026 A new cfg SHALL be accepted no earlier than the cycle after done_o; back-to-back jobs allowed.
REQ-027 busy_o = (state!=IDLE).
REQ-028 Count arithmetic SHALL be unsigned LenWidth; no wrap-around permitted (count never decremented at 0).
REQ-029 Data accepted while stall_i rises in the same cycle SHALL NOT occur: ready depends combinationally on stall_i.

Reset
REQ-030 Asynchronous reset SHALL force state=IDLE, counts=0, bc_data_o='0, bc_valid_o='0, done_o=0, busy_o=0.
REQ-031 Reset mid-job SHALL discard all in-flight strobes; no done_o issued for the aborted job.

Structure
REQ-032 elen_t from ara_pkg; FSM state typedef (bc_seq_state_e) and LenWidth constant SHALL live in matmul_pkg.
REQ-033 Strobe delay line MAY be a sub-module bc_strobe_pipe (NrLanes-bit shift register); otherwise single module.

Verification (NrLanes=4)
REQ-034 len=3, data 0xA,0xB,0xC, no stall -> handshakes t0..t2; bc_valid_o[0] t1..t3, [3] t4..t6; done_o at t6 only.
REQ-035 len=2, stall_i high at t1 for 2 cycles -> elements 0x1 at t0, 0x2 at t3; bc_valid_o[0]=1,0,0,1; bc_data_o holds 0x1 through bubble; done_o at t7.
REQ-036 len=0 -> cfg accepted, no bc_valid_o activity, done_o one cycle later, cfg_ready_o stays high.
REQ-037 Back-to-back jobs len=1 then len=1 -> second cfg accepted cycle after first done_o; two done_o pulses, no strobe overlap errors.
REQ-038 rst_ni asserted during DRAIN of len=4 -> outputs zero immediately, no done_o, next job behaves per REQ-034.
REQ-039 data_valid_i low mid-job for 5 cycles -> FSM stays RUN, bubbles inserted, counts and done timing consistent.
